mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS-style HI/LO multiply/divide unit
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MFRSE,
  input  logic [31:0] MFRTE,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul, is_div, start_op, signed_div;
  logic [63:0] prod_s, prod_u;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, dvsr, uq, ur;
  logic [31:0] pend_hi_d, pend_lo_d;
  logic        pend_wr_d;

  assign is_mul   = (MDOp == 3'd1) || (MDOp == 3'd2);
  assign is_div   = (MDOp == 3'd3) || (MDOp == 3'd4);
  assign start_op = Start && (is_mul || is_div);

  // Operand arithmetic: full products and sign-magnitude division of the current operands
  always_comb begin
    signed_div = (MDOp == 3'd3);
    prod_s     = {{32{MFRSE[31]}}, MFRSE} * {{32{MFRTE[31]}}, MFRTE};
    prod_u     = {32'h0, MFRSE} * {32'h0, MFRTE};
    neg_a      = signed_div && MFRSE[31];
    neg_b      = signed_div && MFRTE[31];
    mag_a      = neg_a ? (32'h0 - MFRSE) : MFRSE;
    mag_b      = neg_b ? (32'h0 - MFRTE) : MFRTE;
    // A zero divisor never commits, so any nonzero stand-in keeps the divider defined.
    dvsr       = (mag_b == 32'h0) ? 32'h1 : mag_b;
    uq         = mag_a / dvsr;
    ur         = mag_a % dvsr;
    pend_hi_d  = 32'h0;
    pend_lo_d  = 32'h0;
    pend_wr_d  = 1'b1;
    case (MDOp)
      3'd1: begin
        pend_hi_d = prod_s[63:32];
        pend_lo_d = prod_s[31:0];
      end
      3'd2: begin
        pend_hi_d = prod_u[63:32];
        pend_lo_d = prod_u[31:0];
      end
      3'd3, 3'd4: begin
        // Quotient sign follows operand signs, remainder follows the dividend.
        pend_lo_d = (neg_a ^ neg_b) ? (32'h0 - uq) : uq;
        pend_hi_d = neg_a ? (32'h0 - ur) : ur;
        pend_wr_d = (MFRTE != 32'h0);
      end
      default: begin
        pend_wr_d = 1'b1;
      end
    endcase
  end

  // Control FSM: accept ops in IDLE, count down the busy period, commit results at the end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_op) begin
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= is_mul ? MULT_N : DIV_N;
            state_q   <= is_mul ? S_MUL : S_DIV;
            busy_q    <= 1'b1;
          end else if (MDOp == 3'd5) begin
            hi_q <= MFRSE;
          end else if (MDOp == 3'd6) begin
            lo_q <= MFRSE;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == 4'd1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed bench with a behavioural HI/LO model
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] MFRSE = 32'h0;
  logic [31:0] MFRTE = 32'h0;
  logic [2:0]  MDOp = 3'd0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MFRSE(MFRSE), .MFRTE(MFRTE),
    .MDOp(MDOp), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // behavioural model: time-stamped operation window plus architectural HI/LO
  int          cyc = 0;
  int          m_start = -100;
  int          m_end = -100;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic [31:0] m_phi = 32'h0, m_plo = 32'h0;
  bit          m_pok = 1'b0;
  bit          chk_en = 1'b0;

  function automatic bit m_busy_at(int c);
    return (c > m_start) && (c <= m_end);
  endfunction

  initial begin : model
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_hi = 32'h0; m_lo = 32'h0; m_phi = 32'h0; m_plo = 32'h0;
        m_pok = 1'b0; m_start = -100; m_end = -100;
        chk_en = 1'b1;
      end else if (m_busy_at(cyc)) begin
        if (cyc == m_end && m_pok) begin
          m_hi = m_phi; m_lo = m_plo;
        end
      end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
        sa = $signed(MFRSE); sb = $signed(MFRTE);
        ua = {32'h0, MFRSE}; ub = {32'h0, MFRTE};
        m_pok = 1'b1;
        case (MDOp)
          3'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; end
          3'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; end
          3'd3: begin
            if (sb == 0) m_pok = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; m_phi = sr[31:0]; m_plo = sq[31:0]; end
          end
          default: begin
            if (ub == 0) m_pok = 1'b0;
            else begin uq = ua / ub; ur = ua % ub; m_phi = ur[31:0]; m_plo = uq[31:0]; end
          end
        endcase
        m_start = cyc;
        m_end   = cyc + ((MDOp <= 3'd2) ? MC : DC);
      end else if (MDOp == 3'd5) begin
        m_hi = MFRSE;
      end else if (MDOp == 3'd6) begin
        m_lo = MFRSE;
      end
      cyc++;
    end
  end

  // compare process: DUT outputs against the model every cycle after the first reset
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_cmp += 3;
        if (Busy !== m_busy_at(cyc)) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b want=%b", cyc, Busy, m_busy_at(cyc));
        end
        if (HI !== m_hi) begin
          n_fail++;
          $display("FAIL hi cyc=%0d got=%h want=%h", cyc, HI, m_hi);
        end
        if (LO !== m_lo) begin
          n_fail++;
          $display("FAIL lo cyc=%0d got=%h want=%h", cyc, LO, m_lo);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // literal expectations on DUT and model, called at a negedge
  task automatic lit(input string name, input logic [31:0] eh, input logic [31:0] el, input logic eb);
    chk({name, "_hi"}, HI, eh);
    chk({name, "_lo"}, LO, el);
    chk({name, "_busy"}, {31'h0, Busy}, {31'h0, eb});
    chk({name, "_mhi"}, m_hi, eh);
    chk({name, "_mlo"}, m_lo, el);
  endtask

  task automatic cyc1(input logic r, input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = r; Start = s; MDOp = op; MFRSE = a; MFRTE = b;
    @(posedge clk); #1;
    reset = 1'b0; Start = 1'b0; MDOp = 3'd0; MFRSE = 32'h0; MFRTE = 32'h0;
  endtask

  task automatic idle(input int n, output int bc);
    bc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Busy) bc++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int bc;
    cyc1(1, 0, 0, 0, 0);
    cyc1(1, 1, 1, 32'd3, 32'd4);
    @(negedge clk);
    lit("reset", 32'h0, 32'h0, 1'b0);

    cyc1(0, 1, 1, 32'hFFFF_FFFE, 32'h3);
    idle(MC, bc);
    chk("mult_busy_cycles", 32'(bc), 32'd5);
    @(negedge clk);
    lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);

    cyc1(0, 1, 2, 32'hFFFF_FFFE, 32'h3);
    idle(MC, bc);
    @(negedge clk);
    lit("multu", 32'h2, 32'hFFFF_FFFA, 1'b0);

    cyc1(0, 1, 3, 32'hFFFF_FFF9, 32'h2);
    idle(DC, bc);
    chk("div_busy_cycles", 32'(bc), 32'd10);
    @(negedge clk);
    lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    cyc1(0, 1, 4, 32'd7, 32'd2);
    idle(DC, bc);
    @(negedge clk);
    lit("divu", 32'h1, 32'h3, 1'b0);

    cyc1(0, 0, 5, 32'h1234, 0);
    cyc1(0, 0, 6, 32'h5678, 0);
    cyc1(0, 1, 4, 32'd99, 32'd0);
    idle(DC, bc);
    chk("div0_busy_cycles", 32'(bc), 32'd10);
    @(negedge clk);
    lit("div0", 32'h1234, 32'h5678, 1'b0);

    cyc1(0, 1, 3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC, bc);
    @(negedge clk);
    lit("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

    // ignored mthi and second Start while busy
    cyc1(0, 1, 1, 32'd3, 32'd4);
    cyc1(0, 0, 0, 0, 0);
    cyc1(0, 0, 5, 32'hAAAA, 0);
    cyc1(0, 1, 3, 32'd9, 32'd2);
    idle(2, bc);
    @(negedge clk);
    lit("busy_ignore", 32'h0, 32'd12, 1'b0);

    cyc1(0, 0, 6, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    lit("mtlo", 32'h0, 32'hDEAD_BEEF, 1'b0);

    // reset in the middle of a divide, then an immediate mult
    cyc1(0, 1, 3, 32'd100, 32'd7);
    cyc1(0, 0, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0);
    cyc1(1, 0, 0, 0, 0);
    @(negedge clk);
    lit("mid_reset", 32'h0, 32'h0, 1'b0);
    cyc1(0, 1, 1, 32'd5, 32'hFFFF_FFFD);
    idle(MC, bc);
    chk("post_reset_busy", 32'(bc), 32'd5);
    @(negedge clk);
    lit("post_reset_mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    // reset outranks Start in the same cycle
    cyc1(1, 1, 1, 32'd5, 32'd5);
    @(negedge clk);
    lit("reset_vs_start", 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      cyc1(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
    end
    idle(DC + 2, bc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
